// File: rtl/counter_up_mod.sv
// Modulo-MODULUS up counter with enable, sync clear, parallel load (clamped),
// cascade carry, a registered wrap pulse and a registered Gray-coded copy of q.
module counter_up_mod #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_gray,
  output logic             carry_out,
  output logic             wrap,
  output logic             load_err
);

  // Terminal count, and the modulus widened by one bit so MODULUS==2**WIDTH
  // still compares correctly against load_val.
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_q_gray;
  logic             r_wrap;
  logic             r_load_err;

  logic [WIDTH-1:0] w_next_q;
  logic             w_next_wrap;
  logic             w_next_err;
  logic             w_at_last;
  logic             w_load_ok;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign w_at_last = (r_q == LAST);
  assign w_load_ok = ({1'b0, load_val} < MOD_EXT);

  // Next-state selection: clear beats load beats count beats hold.
  always_comb begin
    w_next_q    = r_q;
    w_next_wrap = 1'b0;
    w_next_err  = 1'b0;
    if (clr) begin
      w_next_q = '0;
    end else if (load) begin
      if (w_load_ok) begin
        w_next_q = load_val;
      end else begin
        w_next_q   = LAST;
        w_next_err = 1'b1;
      end
    end else if (en) begin
      if (w_at_last) begin
        w_next_q    = '0;
        w_next_wrap = 1'b1;
      end else begin
        w_next_q = r_q + 1'b1;
      end
    end
  end

  // State registers; Gray copy is derived from the same next value so it
  // never lags the binary count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q        <= '0;
      r_q_gray   <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_q        <= w_next_q;
      r_q_gray   <= to_gray(w_next_q);
      r_wrap     <= w_next_wrap;
      r_load_err <= w_next_err;
    end
  end

  // Carry is combinational so a chained stage advances on the same edge.
  assign carry_out = en & ~clr & ~load & w_at_last;

  assign q        = r_q;
  assign q_gray   = r_q_gray;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_counter_up_mod.sv
// Bench for counter_up_mod: directed steps plus randomized traffic, checked
// against an integer reference model. A second instance forms a tens stage.
module tb_counter_up_mod;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk = 1'b0;
  logic         rstn;
  logic         en, clr, load;
  logic [W-1:0] load_val;
  logic [W-1:0] q, q_gray;
  logic         carry_out, wrap, load_err;
  logic [W-1:0] t_q, t_gray;
  logic         t_carry, t_wrap, t_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_q, m_t;
  bit m_wrap, m_err;

  always #5 clk = ~clk;

  counter_up_mod #(.WIDTH(W), .MODULUS(MOD)) u_dut (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .q(q), .q_gray(q_gray), .carry_out(carry_out), .wrap(wrap), .load_err(load_err)
  );

  counter_up_mod #(.WIDTH(W), .MODULUS(MOD)) u_tens (
    .clk(clk), .rstn(rstn), .en(carry_out), .clr(clr), .load(1'b0), .load_val(4'd0),
    .q(t_q), .q_gray(t_gray), .carry_out(t_carry), .wrap(t_wrap), .load_err(t_err)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_q"},    q,        W'(m_q));
    chk({tag, "_gray"}, q_gray,   W'(m_q ^ (m_q >> 1)));
    chk({tag, "_wrap"}, {3'b0, wrap},     {3'b0, m_wrap});
    chk({tag, "_err"},  {3'b0, load_err}, {3'b0, m_err});
    chk({tag, "_tens"}, t_q,      W'(m_t));
  endtask

  // One clock: drive at negedge, check carry before the edge, update model,
  // check registered outputs just after the edge.
  task automatic step(input string tag, input logic e, input logic c, input logic l,
                      input logic [W-1:0] lv);
    bit exp_carry;
    @(negedge clk);
    en = e; clr = c; load = l; load_val = lv;
    #1;
    exp_carry = e && !c && !l && (m_q == MOD - 1);
    chk({tag, "_carry"}, {3'b0, carry_out}, {3'b0, exp_carry});
    @(posedge clk);
    m_err  = 1'b0;
    m_wrap = 1'b0;
    if (c) begin
      m_q = 0;
    end else if (l) begin
      if (int'(lv) < MOD) m_q = int'(lv);
      else begin
        m_q   = MOD - 1;
        m_err = 1'b1;
      end
    end else if (e) begin
      m_wrap = (m_q == MOD - 1);
      m_q    = (m_q + 1) % MOD;
    end
    if (c) m_t = 0;
    else if (exp_carry) m_t = (m_t + 1) % MOD;
    #1;
    chk_all(tag);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
    m_q = 0; m_t = 0; m_wrap = 1'b0; m_err = 1'b0;

    // Reset held for two clocks
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    chk("reset_carry", {3'b0, carry_out}, 4'd0);
    @(negedge clk);
    rstn = 1'b1;
    step("idle", 1'b0, 1'b0, 1'b0, 4'd0);
    step("idle", 1'b0, 1'b0, 1'b0, 4'd0);

    // Free count: 1..9,0,1,2
    for (int i = 1; i <= 12; i++) begin
      step("count", 1'b1, 1'b0, 1'b0, 4'd0);
      if (i == 9) chk("gray_of_9", q_gray, 4'b1101);
    end
    chk("count_end", q, 4'd2);

    // Load in range, then clamped load
    step("load7", 1'b1, 1'b0, 1'b1, 4'd7);
    chk("load7_val", q, 4'd7);
    step("load12", 1'b1, 1'b0, 1'b1, 4'd12);
    chk("load12_clamp", q, 4'd9);
    chk("load12_err", {3'b0, load_err}, 4'd1);

    // Priority: clr + load + en at q=9
    step("prio", 1'b1, 1'b1, 1'b1, 4'd5);
    chk("prio_q", q, 4'd0);

    // Cascade: 25 clocks from 0 -> tens 2, units 5
    for (int i = 0; i < 25; i++) step("casc", 1'b1, 1'b0, 1'b0, 4'd0);
    chk("casc_units", q, 4'd5);
    chk("casc_tens", t_q, 4'd2);

    // Async reset mid-count at q=6
    step("pre_rst", 1'b1, 1'b0, 1'b0, 4'd0);
    chk("pre_rst_q", q, 4'd6);
    #2;
    rstn = 1'b0;
    #1;
    m_q = 0; m_t = 0; m_wrap = 1'b0; m_err = 1'b0;
    chk_all("async_rst");
    chk("async_rst_carry", {3'b0, carry_out}, 4'd0);
    rstn = 1'b1;
    step("post_rst", 1'b1, 1'b0, 1'b0, 4'd0);
    chk("post_rst_q", q, 4'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      step("rand",
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 15) == 0),
           logic'($urandom_range(0, 9) == 0),
           W'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
